// File: rtl/debouncer_pkg.sv
// Shared types and constants for the multi-channel debouncer.
// State encoding and filter-mode selectors used by every channel.
package debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_e;

  localparam int MODE_EARLY   = 0;
  localparam int MODE_DELAYED = 1;

endpackage

// File: rtl/debouncer_channel.sv
// One debounced bit: 2-flop synchroniser, lockout/settle counter, FSM and
// registered edge pulses. MODE picks act-then-lockout or settle-then-act.
module debouncer_channel
  import debouncer_pkg::*;
#(
  parameter int TIMER       = 2_000_000,
  parameter int MODE        = MODE_EARLY,
  parameter int RESET_LEVEL = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy_i,
  output logic debounced_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam int CW = (TIMER > 2) ? $clog2(TIMER) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t       LAST   = cnt_t'(TIMER - 1);
  localparam logic       RL     = (RESET_LEVEL != 0);
  localparam db_state_e  RST_ST = RL ? STABLE_HI : STABLE_LO;
  localparam logic       EARLY  = (MODE == MODE_EARLY);

  logic [1:0] sync_q;
  db_state_e  state_q;
  cnt_t       cnt_q;
  logic       deb_q, rise_q, fall_q;
  logic       s, done;

  assign s    = sync_q[1];
  assign done = (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {2{RL}};
    else       sync_q <= {sync_q[0], noisy_i};
  end

  // Pulses default low so each lasts exactly one cycle alongside the level change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
      deb_q   <= RL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE_LO: if (s) begin
          state_q <= WAIT_HI;
          cnt_q   <= '0;
          if (EARLY) begin
            deb_q  <= 1'b1;
            rise_q <= 1'b1;
          end
        end
        WAIT_HI: begin
          if (!EARLY && !s) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
          end else if (done) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            if (!EARLY) begin
              deb_q  <= 1'b1;
              rise_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        STABLE_HI: if (!s) begin
          state_q <= WAIT_LO;
          cnt_q   <= '0;
          if (EARLY) begin
            deb_q  <= 1'b0;
            fall_q <= 1'b1;
          end
        end
        WAIT_LO: begin
          if (!EARLY && s) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
          end else if (done) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            if (!EARLY) begin
              deb_q  <= 1'b0;
              fall_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        default: begin
          state_q <= RST_ST;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign debounced_o = deb_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign busy_o      = (state_q == WAIT_HI) || (state_q == WAIT_LO);

endmodule

// File: rtl/debouncer_multi.sv
// CHANNELS independent debouncers on one clock; all share TIMER, MODE and
// RESET_LEVEL.
module debouncer_multi
  import debouncer_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int TIMER       = 2_000_000,
  parameter int MODE        = MODE_EARLY,
  parameter int RESET_LEVEL = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy_in,
  output logic [CHANNELS-1:0] debounced_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] busy
);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    debouncer_channel #(
      .TIMER      (TIMER),
      .MODE       (MODE),
      .RESET_LEVEL(RESET_LEVEL)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .noisy_i    (noisy_in[ch]),
      .debounced_o(debounced_out[ch]),
      .rise_o     (rise[ch]),
      .fall_o     (fall[ch]),
      .busy_o     (busy[ch])
    );
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: early and delayed instances share stimulus and
// are compared every cycle against a lock/run-length behavioural model.
module tb_debouncer_multi;
  import debouncer_pkg::*;

  localparam int CH = 4;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] noisy_in;
  logic [CH-1:0] e_deb, e_rise, e_fall, e_busy;
  logic [CH-1:0] d_deb, d_rise, d_fall, d_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debouncer_multi #(.CHANNELS(CH), .TIMER(T), .MODE(MODE_EARLY), .RESET_LEVEL(0)) u_early (
    .clk(clk), .reset(reset), .noisy_in(noisy_in),
    .debounced_out(e_deb), .rise(e_rise), .fall(e_fall), .busy(e_busy));

  debouncer_multi #(.CHANNELS(CH), .TIMER(T), .MODE(MODE_DELAYED), .RESET_LEVEL(0)) u_dly (
    .clk(clk), .reset(reset), .noisy_in(noisy_in),
    .debounced_out(d_deb), .rise(d_rise), .fall(d_fall), .busy(d_busy));

  // Behavioural model: early = lockout countdown, delayed = run length of disagreement.
  logic [CH-1:0] m_s1, m_s2;
  logic [CH-1:0] me_out, me_rise, me_fall, md_out, md_rise, md_fall;
  int            me_lock [CH];
  int            md_run  [CH];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0;
    me_out = '0; me_rise = '0; me_fall = '0;
    md_out = '0; md_rise = '0; md_fall = '0;
    for (int c = 0; c < CH; c++) begin
      me_lock[c] = 0;
      md_run[c]  = 0;
    end
  endtask

  task automatic model_edge();
    logic s;
    for (int c = 0; c < CH; c++) begin
      s = m_s2[c];
      me_rise[c] = 1'b0; me_fall[c] = 1'b0;
      if (me_lock[c] > 0) me_lock[c]--;
      else if (s != me_out[c]) begin
        me_out[c] = s;
        if (s) me_rise[c] = 1'b1; else me_fall[c] = 1'b1;
        me_lock[c] = T;
      end
      md_rise[c] = 1'b0; md_fall[c] = 1'b0;
      if (s == md_out[c]) md_run[c] = 0;
      else begin
        md_run[c]++;
        if (md_run[c] == T + 1) begin
          md_out[c] = s;
          if (s) md_rise[c] = 1'b1; else md_fall[c] = 1'b1;
          md_run[c] = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = noisy_in;
  endtask

  task automatic chk(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [CH-1:0] eb, db;
    for (int c = 0; c < CH; c++) begin
      eb[c] = (me_lock[c] > 0);
      db[c] = (md_run[c] > 0);
    end
    chk("early_deb",  e_deb,  me_out);
    chk("early_rise", e_rise, me_rise);
    chk("early_fall", e_fall, me_fall);
    chk("early_busy", e_busy, eb);
    chk("dly_deb",    d_deb,  md_out);
    chk("dly_rise",   d_rise, md_rise);
    chk("dly_fall",   d_fall, md_fall);
    chk("dly_busy",   d_busy, db);
    chk("early_rise_and_fall", e_rise & e_fall, '0);
    chk("dly_rise_and_fall",   d_rise & d_fall, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    #1;
    compare_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic          rst;
    logic [CH-1:0] noisy;
    logic [CH-1:0] e_deb, e_rise, e_busy;
    logic [CH-1:0] d_deb, d_rise, d_busy;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int nr, nf, dnr, dnf;
    logic [CH-1:0] all1;
    all1 = '1;

    // Reset 3 cycles with inputs high, then release: edge k counted from release.
    for (int i = 0; i < 16; i++) begin
      int k;
      k = i - 3;
      tbl[i].rst    = (i < 3);
      tbl[i].noisy  = all1;
      tbl[i].e_deb  = (k >= 2) ? all1 : '0;
      tbl[i].e_rise = (k == 2) ? all1 : '0;
      tbl[i].e_busy = (k >= 2 && k < 10) ? all1 : '0;
      tbl[i].d_deb  = (k >= 10) ? all1 : '0;
      tbl[i].d_rise = (k == 10) ? all1 : '0;
      tbl[i].d_busy = (k >= 2 && k < 10) ? all1 : '0;
    end

    reset = 1'b1;
    noisy_in = '0;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      reset    = tbl[i].rst;
      noisy_in = tbl[i].noisy;
      tick();
      chk($sformatf("tbl%0d_e_deb", i),  e_deb,  tbl[i].e_deb);
      chk($sformatf("tbl%0d_e_rise", i), e_rise, tbl[i].e_rise);
      chk($sformatf("tbl%0d_e_busy", i), e_busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_d_deb", i),  d_deb,  tbl[i].d_deb);
      chk($sformatf("tbl%0d_d_rise", i), d_rise, tbl[i].d_rise);
      chk($sformatf("tbl%0d_d_busy", i), d_busy, tbl[i].d_busy);
    end

    noisy_in = '0;
    ticks(30);

    // Bounce on ch0: 1,1,0,0,1,1 then held high.
    nr = 0; nf = 0; dnr = 0; dnf = 0;
    for (int j = 0; j < 30; j++) begin
      noisy_in[0] = (j < 6) ? ((j / 2) % 2 == 0) : 1'b1;
      tick();
      nr += int'(e_rise[0]); nf += int'(e_fall[0]);
      dnr += int'(d_rise[0]); dnf += int'(d_fall[0]);
    end
    chk("bounce_e_rise_cnt", 4'(nr), 4'd1);
    chk("bounce_e_fall_cnt", 4'(nf), 4'd0);
    chk("bounce_d_rise_cnt", 4'(dnr), 4'd1);
    chk("bounce_d_fall_cnt", 4'(dnf), 4'd0);
    chk("bounce_e_deb0", {3'b0, e_deb[0]}, 4'b0001);

    // Delayed: 5-cycle glitch on ch1 aborts the settle.
    for (int j = 0; j < 12; j++) begin
      noisy_in[1] = (j < 5);
      tick();
      chk($sformatf("glitch_d_busy1_e%0d", j), {3'b0, d_busy[1]}, {3'b0, (j >= 2 && j <= 6)});
      chk($sformatf("glitch_d_deb1_e%0d", j),  {3'b0, d_deb[1]},  4'b0000);
      chk($sformatf("glitch_d_rise1_e%0d", j), {3'b0, d_rise[1]}, 4'b0000);
    end
    for (int j = 0; j < 20; j++) begin
      noisy_in[1] = 1'b1;
      tick();
      chk($sformatf("hold_d_rise1_e%0d", j), {3'b0, d_rise[1]}, {3'b0, (j == 10)});
      chk($sformatf("hold_d_deb1_e%0d", j),  {3'b0, d_deb[1]},  {3'b0, (j >= 10)});
    end

    // Independence: ch3 pre-settled high, then ch2 rises and ch3 falls together.
    noisy_in[3] = 1'b1;
    ticks(30);
    noisy_in[2] = 1'b1;
    noisy_in[3] = 1'b0;
    for (int j = 0; j < 14; j++) begin
      tick();
      chk($sformatf("indep_e_rise_e%0d", j), e_rise, (j == 2)  ? 4'b0100 : 4'b0000);
      chk($sformatf("indep_e_fall_e%0d", j), e_fall, (j == 2)  ? 4'b1000 : 4'b0000);
      chk($sformatf("indep_d_rise_e%0d", j), d_rise, (j == 10) ? 4'b0100 : 4'b0000);
      chk($sformatf("indep_d_fall_e%0d", j), d_fall, (j == 10) ? 4'b1000 : 4'b0000);
      chk($sformatf("indep_e_deb10_e%0d", j), {2'b0, e_deb[1:0]}, 4'b0011);
    end
    ticks(20);

    // Reset in the middle of WAIT_HI on ch3 (counter at 4 after edge 6).
    noisy_in = 4'b1111;
    ticks(7);
    chk("midwait_pre_e_busy3", {3'b0, e_busy[3]}, 4'b0001);
    reset = 1'b1;
    #1;
    model_reset();
    chk("midwait_async_e_deb",  e_deb,  '0);
    chk("midwait_async_e_busy", e_busy, '0);
    chk("midwait_async_d_deb",  d_deb,  '0);
    chk("midwait_async_d_busy", d_busy, '0);
    ticks(2);
    reset = 1'b0;
    for (int j = 0; j < 14; j++) begin
      tick();
      chk($sformatf("restart_e_rise_e%0d", j), e_rise, (j == 2) ? all1 : '0);
      chk($sformatf("restart_e_busy_e%0d", j), e_busy, (j >= 2 && j < 10) ? all1 : '0);
      chk($sformatf("restart_d_rise_e%0d", j), d_rise, (j == 10) ? all1 : '0);
      chk($sformatf("restart_d_busy_e%0d", j), d_busy, (j >= 2 && j < 10) ? all1 : '0);
    end

    // Random bursty stimulus with occasional resets, checked by the model.
    for (int j = 0; j < 4000; j++) begin
      if ($urandom_range(0, 599) == 0) reset = 1'b1;
      else if (reset && $urandom_range(0, 2) == 0) reset = 1'b0;
      if (reset) model_reset();
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, (j % 200 < 60) ? 2 : 40) == 0) noisy_in[c] = ~noisy_in[c];
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
